rf_wb_arbiter: RTL and testbench

- Shares the register-bank write port between NREQ writeback requesters, fixed as ALU result, load data and JAL link (PC+4).
- Round-robin arbitration over a valid/ready handshake, feeding one registered output stage that drives the register-bank write port.
- Publishes a pending-destination mask so decode can detect read-after-write hazards on the in-flight write.
- Sits between the execute/memory stages and the register bank.

---
 rtl/rf_wb_arbiter_pkg.sv | 15 +
 rtl/rf_wb_arbiter_if.sv | 33 +++
 rtl/rf_wb_arbiter_rr_arbiter.sv | 31 +++
 rtl/rf_wb_arbiter.sv | 92 +++++++++
 tb/tb_rf_wb_arbiter.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-bank writeback arbiter.
// Requester indices, default widths and the hard-wired zero register address.
package rf_wb_arbiter_pkg;

    localparam int unsigned WB_AW   = 5;
    localparam int unsigned WB_DW   = 32;
    localparam int unsigned X0_ADDR = 0;

    typedef enum logic [1:0] {
        WB_SRC_ALU  = 2'd0,
        WB_SRC_LOAD = 2'd1,
        WB_SRC_JAL  = 2'd2
    } wb_src_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus: requester valid/ready handshake plus the register-bank write port.
// The arbiter uses the slave modport; the surrounding pipeline uses master.
interface rf_wb_arbiter_if
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = WB_AW,
    parameter int unsigned DW   = WB_DW
) ();

    logic                 flush_i;
    logic [NREQ-1:0]      req_valid_i;
    logic [NREQ*AW-1:0]   req_addr_i;
    logic [NREQ*DW-1:0]   req_data_i;
    logic [NREQ-1:0]      req_ready_o;
    logic                 rf_busy_i;
    logic                 rf_we_o;
    logic [AW-1:0]        rf_waddr_o;
    logic [DW-1:0]        rf_wdata_o;
    logic [1:0]           rf_wsrc_o;
    logic [31:0]          pend_mask_o;

    modport slave (
        input  flush_i, req_valid_i, req_addr_i, req_data_i, rf_busy_i,
        output req_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, rf_wsrc_o, pend_mask_o
    );

    modport master (
        output flush_i, req_valid_i, req_addr_i, req_data_i, rf_busy_i,
        input  req_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, rf_wsrc_o, pend_mask_o
    );

endinterface

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or after ptr_i,
// wrapping modulo NREQ; no grant at all when en_i is low.
module rr_arbiter #(
    parameter int unsigned NREQ = 3
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [1:0]      ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [1:0]      gnt_idx_o,
    output logic            gnt_vld_o
);

    logic [1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 2'((32'(ptr_i) + k) % NREQ);
            if (en_i && !gnt_vld_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
                gnt_vld_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter feeding a single registered output stage that
// drives the register-bank write port and a pending-destination mask.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = WB_AW,
    parameter int unsigned DW   = WB_DW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    rf_wb_arbiter_if.slave    bus
);

    logic          os_vld_d,  os_vld_q;
    logic [AW-1:0] os_addr_d, os_addr_q;
    logic [DW-1:0] os_data_d, os_data_q;
    logic [1:0]    os_src_d,  os_src_q;
    logic [1:0]    ptr_d,     ptr_q;

    logic            can_accept;
    logic            arb_en;
    logic [NREQ-1:0] gnt;
    logic [1:0]      gnt_idx;
    logic            gnt_vld;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    assign can_accept = !os_vld_q || !bus.rf_busy_i;
    // Reset also masks grants so ready reads zero while rst_i is held.
    assign arb_en     = can_accept && !bus.flush_i && !rst_i;

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .req_i     (bus.req_valid_i),
        .ptr_i     (ptr_q),
        .en_i      (arb_en),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    assign sel_addr = bus.req_addr_i[32'(gnt_idx)*AW +: AW];
    assign sel_data = bus.req_data_i[32'(gnt_idx)*DW +: DW];

    always_comb begin
        os_vld_d  = os_vld_q;
        os_addr_d = os_addr_q;
        os_data_d = os_data_q;
        os_src_d  = os_src_q;
        ptr_d     = ptr_q;
        if (os_vld_q && !bus.rf_busy_i) begin
            os_vld_d = 1'b0;
        end
        if (bus.flush_i) begin
            os_vld_d = 1'b0;
        end
        if (gnt_vld) begin
            ptr_d = (32'(gnt_idx) == NREQ - 1) ? 2'd0 : gnt_idx + 2'd1;
            // x0 writes are consumed but never occupy the output stage.
            if (sel_addr != AW'(X0_ADDR)) begin
                os_vld_d  = 1'b1;
                os_addr_d = sel_addr;
                os_data_d = sel_data;
                os_src_d  = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            os_vld_q  <= 1'b0;
            os_addr_q <= '0;
            os_data_q <= '0;
            os_src_q  <= WB_SRC_ALU;
            ptr_q     <= '0;
        end else begin
            os_vld_q  <= os_vld_d;
            os_addr_q <= os_addr_d;
            os_data_q <= os_data_d;
            os_src_q  <= os_src_d;
            ptr_q     <= ptr_d;
        end
    end

    assign bus.req_ready_o = gnt;
    assign bus.rf_we_o     = os_vld_q;
    assign bus.rf_waddr_o  = os_addr_q;
    assign bus.rf_wdata_o  = os_data_q;
    assign bus.rf_wsrc_o   = os_src_q;
    assign bus.pend_mask_o = os_vld_q ? (32'd1 << os_addr_q) : '0;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed and randomized checks of rf_wb_arbiter against a cycle-level
// behavioural model of the arbitration and output-stage rules.
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    localparam int unsigned NREQ = 3;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0] valid;
    logic [AW-1:0]   addr [NREQ];
    logic [DW-1:0]   data [NREQ];
    logic            busy;
    logic            flush;

    rf_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    assign bus.req_valid_i = valid;
    assign bus.req_addr_i  = {addr[2], addr[1], addr[0]};
    assign bus.req_data_i  = {data[2], data[1], data[0]};
    assign bus.rf_busy_i   = busy;
    assign bus.flush_i     = flush;

    rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    int          m_ptr;
    bit          m_vld;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_src;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_vld = 0; m_addr = '0; m_data = '0; m_src = 0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".we"},    32'(bus.rf_we_o),    32'(m_vld));
        chk({tag, ".waddr"}, 32'(bus.rf_waddr_o), 32'(m_addr));
        chk({tag, ".wdata"}, bus.rf_wdata_o,      m_data);
        chk({tag, ".wsrc"},  32'(bus.rf_wsrc_o),  32'(m_src));
        chk({tag, ".pend"},  bus.pend_mask_o,     m_vld ? (32'd1 << m_addr) : 32'd0);
    endtask

    // One clock: check ready before the edge, advance the model, check outputs after.
    task automatic tick(input string tag, output int g);
        logic [31:0] exp_rdy;
        int idx;
        g = -1;
        if (!flush && !(m_vld && busy)) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && valid[idx]) g = idx;
            end
        end
        exp_rdy = (g >= 0) ? (32'd1 << g) : 32'd0;
        #1;
        chk({tag, ".ready"}, 32'(bus.req_ready_o), exp_rdy);
        @(posedge clk);
        if (m_vld && !busy) m_vld = 0;
        if (flush) m_vld = 0;
        if (g >= 0) begin
            m_ptr = (g + 1) % NREQ;
            if (addr[g] != 0) begin
                m_vld = 1; m_addr = addr[g]; m_data = data[g]; m_src = g;
            end
        end
        #1;
        chk_outputs(tag);
        @(negedge clk);
    endtask

    initial begin
        int g;
        valid = '0; busy = 0; flush = 0;
        for (int i = 0; i < NREQ; i++) begin addr[i] = '0; data[i] = '0; end
        model_reset();

        // Reset values while reset is held
        #12;
        chk("rst.ready", 32'(bus.req_ready_o), 32'd0);
        chk_outputs("rst");
        @(negedge clk);
        rst = 0;

        // JAL write to x1
        valid = 3'b100; addr[2] = 5'd1; data[2] = 32'h0000_0010;
        tick("jal", g);
        chk("jal.pend_const", bus.pend_mask_o, 32'h0000_0002);
        chk("jal.src_const", 32'(bus.rf_wsrc_o), 32'(WB_SRC_JAL));
        valid = '0;
        tick("jal_drain", g);

        // All three requesting continuously
        valid = 3'b111;
        addr[0] = 5'd3; addr[1] = 5'd4; addr[2] = 5'd5;
        data[0] = 32'hA0A0_0000; data[1] = 32'hB1B1_1111; data[2] = 32'hC2C2_2222;
        for (int i = 0; i < 6; i++) tick("rr", g);

        // Backpressure with ALU waiting
        valid = 3'b001; addr[0] = 5'd7; data[0] = 32'h7777_0007; busy = 1;
        for (int i = 0; i < 3; i++) tick("busy", g);
        busy = 0;
        tick("busy_release", g);
        valid = '0;
        tick("busy_drain", g);

        // LOAD to x0 is consumed but dropped; pointer moves on to JAL
        valid = 3'b010; addr[1] = 5'd0; data[1] = 32'hDEAD_BEEF;
        tick("x0", g);
        valid = 3'b111; addr[1] = 5'd4;
        tick("after_x0", g);
        valid = '0;
        tick("after_x0_drain", g);

        // Flush overrides backpressure
        valid = 3'b001; addr[0] = 5'd9; data[0] = 32'h0000_0999;
        tick("pre_flush", g);
        valid = 3'b010; addr[1] = 5'd6; data[1] = 32'h0000_0666; busy = 1; flush = 1;
        tick("flush", g);
        flush = 0; busy = 0; valid = '0;
        tick("post_flush", g);

        // Asynchronous reset with the output stage occupied
        valid = 3'b001; addr[0] = 5'd12; data[0] = 32'h1212_1212;
        tick("pre_rst", g);
        valid = '0; busy = 1;
        #2 rst = 1;
        #1;
        chk("arst.we", 32'(bus.rf_we_o), 32'd0);
        chk("arst.pend", bus.pend_mask_o, 32'd0);
        chk("arst.ready", 32'(bus.req_ready_o), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 0; busy = 0;
        valid = 3'b111; addr[0] = 5'd3; addr[1] = 5'd4; addr[2] = 5'd5;
        tick("post_rst", g);
        valid = '0;
        tick("post_rst_drain", g);

        // Randomized traffic; a requester holds its request until granted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!valid[i] || g == i) begin
                    valid[i] = ($urandom_range(0, 99) < 60);
                    addr[i]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                    data[i]  = $urandom;
                end
            end
            busy  = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 15) == 0);
            tick("rand", g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
